// File: rtl/online_div_scheduler.sv
// Round-robin scheduler that shares one digit-serial online divider between two requesters.
// One operation: clear divider, stream DIGITS operand pairs, drain ONLINE_DELAY cycles, return quotient.
module online_div_scheduler #(
   parameter int DIGITS       = 64,
   parameter int ONLINE_DELAY = 3,
   parameter int CNT_WIDTH    = 11
) (
   input  logic       clk,
   input  logic       asyn_reset,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   input  logic [1:0] x_a,
   input  logic [1:0] d_a,
   input  logic [1:0] x_b,
   input  logic [1:0] d_b,
   output logic       dig_rd,
   output logic [1:0] div_x,
   output logic [1:0] div_d,
   output logic       div_enable_all,
   output logic       div_reset,
   input  logic [1:0] div_q,
   output logic [1:0] q_out,
   output logic       q_valid,
   output logic       q_last,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] FEED_LAST     = CNT_WIDTH'(DIGITS - 1);
   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST    = CNT_WIDTH'(DIGITS + ONLINE_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] CAPTURE_FIRST = CNT_WIDTH'(ONLINE_DELAY);

   function automatic logic digit_illegal(input logic [1:0] dig);
      return (dig == 2'b11);
   endfunction

   function automatic logic [1:0] digit_clean(input logic [1:0] dig);
      return (dig == 2'b11) ? 2'b00 : dig;
   endfunction

   state_t               state_r;
   state_t               next_state_s;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic                 winner_r;
   logic                 rr_ptr_r;
   logic                 pick_s;
   logic                 next_winner_s;
   logic [1:0]           sel_x_s;
   logic [1:0]           sel_d_s;
   logic [1:0]           div_x_s;
   logic [1:0]           div_d_s;
   logic                 illegal_s;
   logic                 capture_s;

   logic [1:0] gnt_nx_s;
   logic       busy_nx_s;
   logic       div_reset_nx_s;
   logic       div_enable_all_nx_s;
   logic       dig_rd_nx_s;

   logic [1:0] gnt_r;
   logic       busy_r;
   logic       div_reset_r;
   logic       div_enable_all_r;
   logic       dig_rd_r;
   logic [1:0] q_out_r;
   logic       q_valid_r;
   logic       q_last_r;
   logic       err_r;

   // Arbitration: a lone request wins outright, a tie goes to the rr pointer side.
   always_comb begin
      pick_s = 1'b0;
      case (req)
         2'b01:   pick_s = 1'b0;
         2'b10:   pick_s = 1'b1;
         2'b11:   pick_s = rr_ptr_r;
         default: pick_s = 1'b0;
      endcase
   end

   always_comb begin
      if ((state_r == IDLE) && (req != 2'b00)) begin
         next_winner_s = pick_s;
      end else begin
         next_winner_s = winner_r;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (req != 2'b00) begin
               next_state_s = CLEAR;
            end else begin
               next_state_s = IDLE;
            end
         end
         CLEAR: next_state_s = FEED;
         FEED: begin
            if (cnt_r == FEED_LAST) begin
               next_state_s = (ONLINE_DELAY > 0) ? DRAIN : DONE;
            end else begin
               next_state_s = FEED;
            end
         end
         DRAIN: begin
            if (cnt_r == DRAIN_LAST) begin
               next_state_s = DONE;
            end else begin
               next_state_s = DRAIN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state so the control outputs leave a register.
   always_comb begin
      gnt_nx_s            = 2'b00;
      busy_nx_s           = 1'b0;
      div_reset_nx_s      = 1'b0;
      div_enable_all_nx_s = 1'b0;
      dig_rd_nx_s         = 1'b0;
      case (next_state_s)
         IDLE: begin
            gnt_nx_s  = 2'b00;
            busy_nx_s = 1'b0;
         end
         CLEAR: begin
            gnt_nx_s       = next_winner_s ? 2'b10 : 2'b01;
            busy_nx_s      = 1'b1;
            div_reset_nx_s = 1'b1;
         end
         FEED: begin
            gnt_nx_s            = next_winner_s ? 2'b10 : 2'b01;
            busy_nx_s           = 1'b1;
            div_enable_all_nx_s = 1'b1;
            dig_rd_nx_s         = 1'b1;
         end
         DRAIN: begin
            gnt_nx_s            = next_winner_s ? 2'b10 : 2'b01;
            busy_nx_s           = 1'b1;
            div_enable_all_nx_s = 1'b1;
         end
         DONE: begin
            busy_nx_s = 1'b1;
         end
         default: begin
            gnt_nx_s  = 2'b00;
            busy_nx_s = 1'b0;
         end
      endcase
   end

   // Control registers: grant, pointer, digit counter and registered control outputs.
   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         winner_r         <= 1'b0;
         rr_ptr_r         <= 1'b0;
         cnt_r            <= {CNT_WIDTH{1'b0}};
         gnt_r            <= 2'b00;
         busy_r           <= 1'b0;
         div_reset_r      <= 1'b0;
         div_enable_all_r <= 1'b0;
         dig_rd_r         <= 1'b0;
      end else begin
         winner_r         <= next_winner_s;
         gnt_r            <= gnt_nx_s;
         busy_r           <= busy_nx_s;
         div_reset_r      <= div_reset_nx_s;
         div_enable_all_r <= div_enable_all_nx_s;
         dig_rd_r         <= dig_rd_nx_s;
         if (state_r == DONE) begin
            rr_ptr_r <= ~winner_r;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
         case (state_r)
            CLEAR:       cnt_r <= {CNT_WIDTH{1'b0}};
            FEED, DRAIN: cnt_r <= cnt_r + CNT_WIDTH'(1);
            default:     cnt_r <= cnt_r;
         endcase
      end
   end

   // Operand path: granted requester's digits during FEED, zeros otherwise.
   always_comb begin
      sel_x_s = winner_r ? x_b : x_a;
      sel_d_s = winner_r ? d_b : d_a;
      if (state_r == FEED) begin
         div_x_s   = digit_clean(sel_x_s);
         div_d_s   = digit_clean(sel_d_s);
         illegal_s = digit_illegal(sel_x_s) | digit_illegal(sel_d_s);
      end else begin
         div_x_s   = 2'b00;
         div_d_s   = 2'b00;
         illegal_s = 1'b0;
      end
   end

   // Sticky illegal-digit flag, scoped to one operation.
   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         err_r <= 1'b0;
      end else if (state_r == CLEAR) begin
         err_r <= 1'b0;
      end else if (illegal_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Digits produced before the online delay has elapsed carry no information.
   always_comb begin
      if ((state_r == FEED) || (state_r == DRAIN)) begin
         capture_s = (cnt_r >= CAPTURE_FIRST);
      end else begin
         capture_s = 1'b0;
      end
   end

   // Quotient return register.
   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         q_out_r   <= 2'b00;
         q_valid_r <= 1'b0;
         q_last_r  <= 1'b0;
      end else if (capture_s) begin
         q_out_r   <= div_q;
         q_valid_r <= 1'b1;
         q_last_r  <= (cnt_r == DRAIN_LAST);
      end else begin
         q_out_r   <= 2'b00;
         q_valid_r <= 1'b0;
         q_last_r  <= 1'b0;
      end
   end

   assign gnt            = gnt_r;
   assign busy           = busy_r;
   assign div_reset      = div_reset_r;
   assign div_enable_all = div_enable_all_r;
   assign dig_rd         = dig_rd_r;
   assign div_x          = div_x_s;
   assign div_d          = div_d_s;
   assign q_out          = q_out_r;
   assign q_valid        = q_valid_r;
   assign q_last         = q_last_r;
   assign err            = err_r;

endmodule

// File: tb/tb_online_div_scheduler.sv
// Randomized bench for online_div_scheduler against an operation-timeline reference model.
module tb_online_div_scheduler;

   localparam int D  = 8;
   localparam int OD = 3;

   logic       clk;
   logic       asyn_reset;
   logic [1:0] req;
   logic [1:0] gnt;
   logic [1:0] x_a, d_a, x_b, d_b;
   logic       dig_rd;
   logic [1:0] div_x, div_d;
   logic       div_enable_all;
   logic       div_reset;
   logic [1:0] div_q;
   logic [1:0] q_out;
   logic       q_valid, q_last, busy, err;

   online_div_scheduler #(.DIGITS(D), .ONLINE_DELAY(OD), .CNT_WIDTH(11)) dut (
      .clk            (clk),
      .asyn_reset     (asyn_reset),
      .req            (req),
      .gnt            (gnt),
      .x_a            (x_a),
      .d_a            (d_a),
      .x_b            (x_b),
      .d_b            (d_b),
      .dig_rd         (dig_rd),
      .div_x          (div_x),
      .div_d          (div_d),
      .div_enable_all (div_enable_all),
      .div_reset      (div_reset),
      .div_q          (div_q),
      .q_out          (q_out),
      .q_valid        (q_valid),
      .q_last         (q_last),
      .busy           (busy),
      .err            (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_now = 0;

   // Reference model: an operation is a timeline indexed by k (k=0 clear, k=1..D feed,
   // then OD drain cycles, then the done cycle); t = k-1 is the digit index.
   bit         m_act = 1'b0;
   int         m_k   = 0;
   bit         m_win = 1'b0;
   bit         m_ptr = 1'b0;
   bit         m_err = 1'b0;
   bit         m_qv  = 1'b0;
   bit         m_ql  = 1'b0;
   logic [1:0] m_q   = 2'b00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_now, got, exp);
      end
   endtask

   function automatic logic [1:0] clean(input logic [1:0] v);
      return (v == 2'b11) ? 2'b00 : v;
   endfunction

   function automatic logic [1:0] rand_digit(input bit allow_illegal);
      logic [1:0] v;
      if (allow_illegal && ($urandom_range(0, 15) == 0)) begin
         v = 2'b11;
      end else begin
         case ($urandom_range(0, 2))
            0:       v = 2'b00;
            1:       v = 2'b10;
            default: v = 2'b01;
         endcase
      end
      return v;
   endfunction

   task automatic run_cycle(input logic [1:0] r, input logic [1:0] xa, input logic [1:0] da,
                            input logic [1:0] xb, input logic [1:0] db, input logic [1:0] q,
                            input logic rs);
      logic [1:0] sx, sd, e_gnt, e_x, e_d, onehot;
      logic       e_busy, e_rst, e_en, e_rd;
      int         t;
      req = r; x_a = xa; d_a = da; x_b = xb; d_b = db; div_q = q; asyn_reset = rs;
      #4;
      sx     = m_win ? xb : xa;
      sd     = m_win ? db : da;
      onehot = m_win ? 2'b10 : 2'b01;
      e_gnt = 2'b00; e_x = 2'b00; e_d = 2'b00;
      e_busy = 1'b0; e_rst = 1'b0; e_en = 1'b0; e_rd = 1'b0;
      if (m_act) begin
         e_busy = 1'b1;
         if (m_k == 0) begin
            e_gnt = onehot; e_rst = 1'b1;
         end else if (m_k <= D) begin
            e_gnt = onehot; e_en = 1'b1; e_rd = 1'b1; e_x = clean(sx); e_d = clean(sd);
         end else if (m_k <= D + OD) begin
            e_gnt = onehot; e_en = 1'b1;
         end
      end
      check_eq("gnt",       32'(gnt),            32'(e_gnt));
      check_eq("busy",      32'(busy),           32'(e_busy));
      check_eq("div_reset", 32'(div_reset),      32'(e_rst));
      check_eq("div_en",    32'(div_enable_all), 32'(e_en));
      check_eq("dig_rd",    32'(dig_rd),         32'(e_rd));
      check_eq("div_x",     32'(div_x),          32'(e_x));
      check_eq("div_d",     32'(div_d),          32'(e_d));
      check_eq("q_valid",   32'(q_valid),        32'(m_qv));
      check_eq("q_last",    32'(q_last),         32'(m_ql));
      check_eq("err",       32'(err),            32'(m_err));
      if (m_qv) check_eq("q_out", 32'(q_out), 32'(m_q));

      if (rs) begin
         m_act = 1'b0; m_k = 0; m_win = 1'b0; m_ptr = 1'b0; m_err = 1'b0;
         m_qv = 1'b0; m_ql = 1'b0; m_q = 2'b00;
      end else begin
         t = m_k - 1;
         if (m_act && (m_k >= 1) && (m_k <= D + OD) && (t >= OD)) begin
            m_qv = 1'b1; m_q = q; m_ql = (t == D + OD - 1);
         end else begin
            m_qv = 1'b0; m_ql = 1'b0;
         end
         if (m_act && (m_k == 0)) m_err = 1'b0;
         else if (m_act && (m_k >= 1) && (m_k <= D) && ((sx == 2'b11) || (sd == 2'b11))) m_err = 1'b1;
         if (!m_act) begin
            if (r != 2'b00) begin
               m_win = (r == 2'b11) ? m_ptr : (r == 2'b10);
               m_act = 1'b1;
               m_k   = 0;
            end
         end else if (m_k == D + OD + 1) begin
            m_ptr = ~m_win;
            m_act = 1'b0;
         end else begin
            m_k++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] r, xa, da, xb, db, q;
      logic       rs;
      bit         rst_seen;
      rst_seen   = 1'b0;
      asyn_reset = 1'b1;
      req = 2'b00; x_a = 2'b00; d_a = 2'b00; x_b = 2'b00; d_b = 2'b00; div_q = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 2400; cyc++) begin
         cyc_now = cyc;
         rs = 1'b0;
         q  = rand_digit(1'b1);
         if (cyc < 110) begin
            xa = rand_digit(1'b0); da = rand_digit(1'b0);
            xb = rand_digit(1'b0); db = rand_digit(1'b0);
         end else begin
            xa = rand_digit(1'b1); da = rand_digit(1'b1);
            xb = rand_digit(1'b1); db = rand_digit(1'b1);
         end
         if (cyc < 20) begin
            r = (cyc == 0) ? 2'b01 : 2'b00;
         end else if (cyc < 50) begin
            r = 2'b11;
         end else if (cyc < 70) begin
            r = 2'b01;
            if (m_act && (m_k == 3)) xa = 2'b11;
         end else if (cyc < 90) begin
            r = rst_seen ? 2'b11 : 2'b01;
            if (!rst_seen && m_act && (m_k == 6)) begin
               rs = 1'b1;
               rst_seen = 1'b1;
            end
         end else if (cyc < 110) begin
            r = (m_act && (m_k >= 2)) ? 2'b00 : 2'b10;
         end else begin
            r  = 2'($urandom_range(0, 3));
            rs = ($urandom_range(0, 249) == 0);
         end
         run_cycle(r, xa, da, xb, db, q, rs);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
